// File: rtl/out_layer5_classifier.sv
// out_layer5_classifier: serial-MAC output layer with arg-max selection.
// A single multiplier walks weight(c,i) * frame[i] for every class c and input i,
// one product per cycle, and keeps the best signed logit seen so far.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_valid/in_ready moves one frame in. out_valid/out_ready moves one
// result out, and class_id/score hold steady while out_valid is high.
module out_layer5_classifier #(
  parameter int                   NIN     = 16,
  parameter int                   NCLS    = 4,
  parameter logic [NCLS*NIN*8-1:0] WEIGHTS = '0,
  parameter logic [NCLS*24-1:0]    BIASES  = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NIN*24-1:0]        a_vec,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(NCLS)-1:0]  class_id,
  output logic [23:0]              score,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               dbg_state
);

  localparam int CW = $clog2(NCLS);
  localparam int IW = $clog2(NIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NIN*24-1:0] frame_q, frame_d;
  logic [CW-1:0]     c_q, c_d;
  logic [IW-1:0]     i_q, i_d;
  logic [23:0]       acc_q, acc_d;
  logic [23:0]       best_score_q, best_score_d;
  logic [CW-1:0]     best_id_q, best_id_d;
  logic [CW-1:0]     class_id_q, class_id_d;
  logic [23:0]       score_q, score_d;
  logic              out_valid_q, out_valid_d;

  logic [7:0]        w8;
  logic [23:0]       w_ext;
  logic [23:0]       act;
  logic [23:0]       prod;
  logic [23:0]       acc_sum;
  logic [CW-1:0]     c_nxt;

  // Datapath: current weight/activation, truncated product and running sum.
  always_comb begin
    w8      = WEIGHTS[(int'(c_q) * NIN + int'(i_q)) * 8 +: 8];
    w_ext   = {{16{w8[7]}}, w8};
    act     = frame_q[int'(i_q) * 24 +: 24];
    prod    = act * w_ext;
    acc_sum = acc_q + prod;
    c_nxt   = c_q + 1'b1;
  end

  // Next-state and register updates for the accept / MAC / report sequence.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    c_d          = c_q;
    i_d          = i_q;
    acc_d        = acc_q;
    best_score_d = best_score_q;
    best_id_d    = best_id_q;
    class_id_d   = class_id_q;
    score_d      = score_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          frame_d      = a_vec;
          c_d          = '0;
          i_d          = '0;
          acc_d        = BIASES[23:0];
          best_score_d = 24'h800000;
          best_id_d    = '0;
          state_d      = S_MAC;
        end
      end
      S_MAC: begin
        if (i_q == IW'(NIN - 1)) begin
          // Strict compare keeps the lowest class index on a tie.
          if ($signed(acc_sum) > $signed(best_score_q)) begin
            best_score_d = acc_sum;
            best_id_d    = c_q;
          end
          i_d = '0;
          c_d = c_nxt;
          if (c_q == CW'(NCLS - 1)) begin
            acc_d   = '0;
            state_d = S_FINAL;
          end else begin
            acc_d = BIASES[int'(c_nxt) * 24 +: 24];
          end
        end else begin
          acc_d = acc_sum;
          i_d   = i_q + 1'b1;
        end
      end
      S_FINAL: begin
        class_id_d  = best_id_q;
        score_d     = best_score_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      frame_q      <= '0;
      c_q          <= '0;
      i_q          <= '0;
      acc_q        <= '0;
      best_score_q <= '0;
      best_id_q    <= '0;
      class_id_q   <= '0;
      score_q      <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      c_q          <= c_d;
      i_q          <= i_d;
      acc_q        <= acc_d;
      best_score_q <= best_score_d;
      best_id_q    <= best_id_d;
      class_id_q   <= class_id_d;
      score_q      <= score_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && reset;
  assign class_id  = class_id_q;
  assign score     = score_q;
  assign out_valid = out_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_out_layer5_classifier.sv
// Testbench for out_layer5_classifier: four instances with different weight and
// bias sets share the same input stimulus. Each result is compared against a
// sum-of-products reference model and against hand-derived table values.
module tb_out_layer5_classifier;

  localparam int NIN  = 16;
  localparam int NCLS = 4;
  localparam int AW   = NIN * 24;
  localparam int WW   = NCLS * NIN * 8;
  localparam int BW   = NCLS * 24;

  function automatic logic [WW-1:0] mk_single();
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < NIN; i++) w[(2 * NIN + i) * 8 +: 8] = 8'd1;
    return w;
  endfunction

  function automatic logic [WW-1:0] mk_rand();
    logic [WW-1:0] w;
    logic [31:0]   x;
    w = '0;
    x = 32'h1234567;
    for (int k = 0; k < NCLS * NIN; k++) begin
      x = x * 32'd1103515245 + 32'd12345;
      w[k * 8 +: 8] = x[23:16];
    end
    return w;
  endfunction

  localparam logic [WW-1:0] W_A = mk_single();
  localparam logic [BW-1:0] B_A = '0;
  localparam logic [WW-1:0] W_B = {{(WW-8){1'b0}}, 8'h7F} << ((3 * NIN + 0) * 8);
  localparam logic [BW-1:0] B_B = {24'h000000, 24'hFFFFFD, 24'h000005, 24'h000005};
  localparam logic [WW-1:0] W_C = '0;
  localparam logic [BW-1:0] B_C = {24'hFFFFFC, 24'hFFFFF7, 24'hFFFFFE, 24'hFFFFF9};
  localparam logic [WW-1:0] W_D = mk_rand();
  localparam logic [BW-1:0] B_D = {24'h001234, 24'hFFF000, 24'h000000, 24'h7FF000};

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] a_vec;
  logic          in_valid;
  logic          out_ready;
  logic          ir  [4];
  logic [1:0]    cid [4];
  logic [23:0]   sc  [4];
  logic          ov  [4];
  logic [1:0]    dbg [4];

  always #5 clk = ~clk;

  out_layer5_classifier #(.NIN(NIN), .NCLS(NCLS), .WEIGHTS(W_A), .BIASES(B_A)) u_a (
    .clk(clk), .reset(reset), .a_vec(a_vec), .in_valid(in_valid), .in_ready(ir[0]),
    .class_id(cid[0]), .score(sc[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .dbg_state(dbg[0]));
  out_layer5_classifier #(.NIN(NIN), .NCLS(NCLS), .WEIGHTS(W_B), .BIASES(B_B)) u_b (
    .clk(clk), .reset(reset), .a_vec(a_vec), .in_valid(in_valid), .in_ready(ir[1]),
    .class_id(cid[1]), .score(sc[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .dbg_state(dbg[1]));
  out_layer5_classifier #(.NIN(NIN), .NCLS(NCLS), .WEIGHTS(W_C), .BIASES(B_C)) u_c (
    .clk(clk), .reset(reset), .a_vec(a_vec), .in_valid(in_valid), .in_ready(ir[2]),
    .class_id(cid[2]), .score(sc[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .dbg_state(dbg[2]));
  out_layer5_classifier #(.NIN(NIN), .NCLS(NCLS), .WEIGHTS(W_D), .BIASES(B_D)) u_d (
    .clk(clk), .reset(reset), .a_vec(a_vec), .in_valid(in_valid), .in_ready(ir[3]),
    .class_id(cid[3]), .score(sc[3]), .out_valid(ov[3]), .out_ready(out_ready),
    .dbg_state(dbg[3]));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [1:0]  got_id [4];
  logic [23:0] got_sc [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: logit(c) = bias(c) + sum_i a_i * w(c,i), reduced mod 2^24 and read
  // as signed; winner is the first class holding the maximum logit.
  function automatic void model(input logic [AW-1:0] f, input logic [WW-1:0] w,
                                input logic [BW-1:0] b, output logic [1:0] id,
                                output logic [23:0] s);
    longint sum;
    logic [23:0] logit;
    int best;
    best = -(1 << 23);
    id = 2'd0;
    s  = 24'h800000;
    for (int c = 0; c < NCLS; c++) begin
      sum = longint'($signed(b[c * 24 +: 24]));
      for (int i = 0; i < NIN; i++)
        sum += longint'(f[i * 24 +: 24]) * longint'($signed(w[(c * NIN + i) * 8 +: 8]));
      logit = sum[23:0];
      if (int'($signed(logit)) > best) begin
        best = int'($signed(logit));
        id   = 2'(c);
        s    = logit;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Sends one frame (caller ensures in_ready), waits for the result, checks it
  // against the model for all instances, and optionally completes the handshake.
  task automatic run_frame(input logic [AW-1:0] f, input bit hs);
    int lat;
    logic [1:0]  eid;
    logic [23:0] esc;
    check("in_ready_before_accept", 32'(ir[0]), 32'd1);
    a_vec    = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_vec    = {12{$urandom}};
    lat = 0;
    @(negedge clk);
    while (!ov[0] && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'd65);
    for (int k = 0; k < 4; k++) begin
      got_id[k] = cid[k];
      got_sc[k] = sc[k];
    end
    model(f, W_A, B_A, eid, esc);
    check("model_id_a", 32'(got_id[0]), 32'(eid));
    check("model_sc_a", 32'(got_sc[0]), 32'(esc));
    model(f, W_B, B_B, eid, esc);
    check("model_id_b", 32'(got_id[1]), 32'(eid));
    check("model_sc_b", 32'(got_sc[1]), 32'(esc));
    model(f, W_C, B_C, eid, esc);
    check("model_id_c", 32'(got_id[2]), 32'(eid));
    check("model_sc_c", 32'(got_sc[2]), 32'(esc));
    model(f, W_D, B_D, eid, esc);
    check("model_id_d", 32'(got_id[3]), 32'(eid));
    check("model_sc_d", 32'(got_sc[3]), 32'(esc));
    if (hs) begin
      @(posedge clk);
      @(negedge clk);
      check("out_valid_after_hs", 32'(ov[0]), 32'd0);
      check("in_ready_after_hs", 32'(ir[0]), 32'd1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic [AW-1:0] frame;
    int            inst;
    logic [1:0]    id;
    logic [23:0]   sc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [AW-1:0] tens;
    logic [AW-1:0] wrapf;
    logic [AW-1:0] rf;
    logic [1:0]    hold_id;
    logic [23:0]   hold_sc;
    int            ov_seen;

    tens  = {NIN{24'd10}};
    wrapf = '0;
    wrapf[23:0] = 24'h7FFFFF;
    tbl[0] = '{"single_active", tens,  0, 2'd2, 24'd160};
    tbl[1] = '{"tie_biases",    '0,    1, 2'd0, 24'd5};
    // 0x7FFFFF * 127 truncates to 0x7FFF81, which is positive, so class 3 wins.
    tbl[2] = '{"wrap_product",  wrapf, 1, 2'd3, 24'h7FFF81};
    tbl[3] = '{"all_negative",  '0,    2, 2'd1, 24'hFFFFFE};
    tbl[4] = '{"tens_on_b",     tens,  1, 2'd3, 24'd1270};
    tbl[5] = '{"zero_on_a",     '0,    0, 2'd0, 24'd0};

    // Reset with in_valid held high.
    reset     = 1'b0;
    in_valid  = 1'b1;
    a_vec     = tens;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready",  32'(ir[k]),  32'd0);
      check("rst_out_valid", 32'(ov[k]),  32'd0);
      check("rst_class_id",  32'(cid[k]), 32'd0);
      check("rst_score",     32'(sc[k]),  32'd0);
    end
    reset = 1'b1;
    #1;
    check("release_in_ready", 32'(ir[0]), 32'd1);

    // Table vectors (first one is accepted on the first edge after release).
    for (int v = 0; v < 6; v++) begin
      run_frame(tbl[v].frame, 1'b1);
      check({tbl[v].name, "_id"}, 32'(got_id[tbl[v].inst]), 32'(tbl[v].id));
      check({tbl[v].name, "_sc"}, 32'(got_sc[tbl[v].inst]), 32'(tbl[v].sc));
    end

    // Backpressure: result held for 10 cycles while the input side toggles.
    out_ready = 1'b0;
    run_frame(tens, 1'b0);
    hold_id = cid[0];
    hold_sc = sc[0];
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a_vec    = {12{$urandom}};
      @(negedge clk);
      check("bp_out_valid", 32'(ov[0]),  32'd1);
      check("bp_in_ready",  32'(ir[0]),  32'd0);
      check("bp_class_id",  32'(cid[0]), 32'(hold_id));
      check("bp_score",     32'(sc[0]),  32'(hold_sc));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 32'(ov[0]), 32'd0);
    check("bp_release_in_ready",  32'(ir[0]), 32'd1);
    // Next frame must be the one sent now, not anything toggled in earlier.
    run_frame(tens, 1'b1);
    check("bp_next_id", 32'(got_id[0]), 32'd2);
    check("bp_next_sc", 32'(got_sc[0]), 32'd160);

    // Reset 30 cycles into a frame: no result may appear for it.
    ov_seen  = 0;
    a_vec    = {NIN{24'd99}};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ov[0]) ov_seen++;
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(ov[0]),  32'd0);
    check("midrst_class_id",  32'(cid[0]), 32'd0);
    check("midrst_score",     32'(sc[0]),  32'd0);
    check("midrst_in_ready",  32'(ir[0]),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (ov[0]) ov_seen++;
    end
    check("midrst_no_pulse", 32'(ov_seen), 32'd0);
    run_frame(tens, 1'b1);
    check("midrst_next_id", 32'(got_id[0]), 32'd2);
    check("midrst_next_sc", 32'(got_sc[0]), 32'd160);

    // Randomized frames: small ReLU-range values and full 24-bit values.
    for (int r = 0; r < 16; r++) begin
      rf = '0;
      for (int i = 0; i < NIN; i++) begin
        if (r < 8) rf[i * 24 +: 24] = 24'($urandom_range(0, 255));
        else       rf[i * 24 +: 24] = 24'($urandom);
      end
      run_frame(rf, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
